// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle MIPS multiply/divide unit with HI/LO registers and a busy stall.
// Define MDU_MADD_EN to enable op 6/7 (MADD/MADDU) multiply-accumulate into HI/LO.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        commit_q, commit_d;
  logic        sgn, is_mul, is_div;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] abs_a, abs_b, uq, ur, quo, rem;
  always_comb begin
    sgn    = ~op[0];
    ext_a  = {{32{sgn & A[31]}}, A};
    ext_b  = {{32{sgn & B[31]}}, B};
    prod   = ext_a * ext_b;
    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
    abs_a  = (sgn && A[31]) ? -A : A;
    abs_b  = (sgn && B[31]) ? -B : B;
    uq     = (abs_b == '0) ? '0 : abs_a / abs_b;
    ur     = (abs_b == '0) ? '0 : abs_a % abs_b;
    quo    = (sgn && (A[31] ^ B[31])) ? -uq : uq;
    rem    = (sgn && A[31]) ? -ur : ur;
`ifdef MDU_MADD_EN
    is_mul = (op[2:1] == 2'b00) || (op[2:1] == 2'b11);
`else
    is_mul = op[2:1] == 2'b00;
`endif
    is_div = op[2:1] == 2'b01;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (state_q == RUN) begin
      cnt_d = cnt_q - 32'd1;
      if (cnt_q == 32'd1) begin
        state_d = IDLE;
        if (commit_q) {hi_d, lo_d} = pend_q;
      end
    end else if (start) begin
      if (is_mul) begin
        state_d  = RUN;
        cnt_d    = MULT_CYCLES;
        commit_d = 1'b1;
`ifdef MDU_MADD_EN
        pend_d   = op[2] ? {hi_q, lo_q} + prod : prod;
`else
        pend_d   = prod;
`endif
      end else if (is_div) begin
        state_d  = RUN;
        cnt_d    = DIV_CYCLES;
        commit_d = B != '0;
        pend_d   = {rem, quo};
      end else if (op == 3'd4) begin
        hi_d = A;
      end else if (op == 3'd5) begin
        lo_d = A;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= '0;
      commit_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
  assign busy = state_q == RUN;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed and random checks of mdu_hilo against an arithmetic HI/LO reference model.
module tb_mdu_hilo;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] A = '0, B = '0;
  logic        busy;
  logic [31:0] hi, lo;
  logic [31:0] mh = '0, ml = '0;
  int          checks = 0, errors = 0;

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted op; n is the expected busy length.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l, output int n);
    longint sa, sb, q, r;
    logic [63:0] acc, up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    up  = {32'b0, a} * {32'b0, b};
    acc = {h, l};
    n   = 0;
    case (o)
      3'd0: begin {h, l} = sa * sb; n = MC; end
      3'd1: begin {h, l} = up; n = MC; end
      3'd2: begin
        n = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      3'd3: begin
        n = DC;
        if (b != 0) begin l = a / b; h = a % b; end
      end
      3'd4: h = a;
      3'd5: l = a;
`ifdef MDU_MADD_EN
      3'd6: begin {h, l} = acc + 64'(sa * sb); n = MC; end
      3'd7: begin {h, l} = acc + up; n = MC; end
`endif
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the op has fully completed.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int noise);
    int n;
    logic [31:0] oh, ol;
    oh = mh; ol = ml;
    start = 1'b1; op = o; A = a; B = b;
    model(o, a, b, mh, ml, n);
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom;
    for (int i = 1; i <= n; i++) begin
      if (noise == 1) begin start = 1'b1; op = 3'd5; A = 32'hDEAD; end
      else if (noise == 2) begin start = 1'b1; op = 3'($urandom); A = $urandom; B = $urandom; end
      @(negedge clk);
      chk($sformatf("busy op%0d cyc%0d", o, i), {31'b0, busy}, 32'd1);
      chk($sformatf("hi hold op%0d cyc%0d", o, i), hi, oh);
      chk($sformatf("lo hold op%0d cyc%0d", o, i), lo, ol);
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("busy done op%0d", o), {31'b0, busy}, 32'd0);
    chk($sformatf("hi op%0d a=%h b=%h", o, a, b), hi, mh);
    chk($sformatf("lo op%0d a=%h b=%h", o, a, b), lo, ml);
  endtask

  initial begin
    start = 1'b1; op = 3'd4; A = 32'h1234;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    run(3'd0, 32'hFFFFFFFE, 32'd3, 0);
    chk("mult hi", hi, 32'hFFFFFFFF);
    chk("mult lo", lo, 32'hFFFFFFFA);
    run(3'd1, 32'hFFFFFFFE, 32'd3, 0);
    chk("multu hi", hi, 32'h00000002);
    chk("multu lo", lo, 32'hFFFFFFFA);
    run(3'd2, 32'hFFFFFFF9, 32'd2, 0);
    chk("div hi", hi, 32'hFFFFFFFF);
    chk("div lo", lo, 32'hFFFFFFFD);
    run(3'd3, 32'd100, 32'd7, 0);
    chk("divu hi", hi, 32'd2);
    chk("divu lo", lo, 32'd14);
    run(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div ovf hi", hi, 32'h0);
    chk("div ovf lo", lo, 32'h80000000);

    run(3'd4, 32'hAAAA, 32'd0, 0);
    run(3'd5, 32'h5555, 32'd0, 0);
    run(3'd2, 32'd5, 32'd0, 0);
    chk("div0 hi", hi, 32'hAAAA);
    chk("div0 lo", lo, 32'h5555);
    run(3'd3, 32'd9, 32'd0, 2);

    run(3'd4, 32'd0, 32'd0, 0);
    run(3'd5, 32'd0, 32'd0, 0);
    run(3'd0, 32'd3, 32'd4, 1);
    chk("busy-ignore lo", lo, 32'd12);
    chk("busy-ignore hi", hi, 32'd0);
    run(3'd0, 32'd7, 32'd6, 0);
    chk("back2back lo", lo, 32'd42);
    run(3'd6, 32'd1, 32'd1, 0);
    run(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

    for (int k = 0; k < 60; k++)
      run(3'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, int'($urandom_range(0, 2)));

    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midreset busy before", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mh = '0; ml = '0;
    @(negedge clk);
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midreset late busy", {31'b0, busy}, 32'd0);
    chk("midreset late hi", hi, 32'd0);
    chk("midreset late lo", lo, 32'd0);

`ifdef MDU_MADD_EN
    run(3'd5, 32'hFFFFFFFF, 32'd0, 0);
    run(3'd7, 32'd1, 32'd1, 0);
    chk("maddu hi", hi, 32'd1);
    chk("maddu lo", lo, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
